// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - host byte stream and instruction-memory write port bundle
interface imem_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - assembles LE bytes into words and writes them to instruction memory
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    imem_loader_if.slave      bus,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t          state;
    logic [ADDR_W:0] len_q;
    logic [ADDR_W:0] word_idx;
    logic [ADDR_W:0] word_next;
    logic [1:0]      byte_cnt;
    logic [23:0]     word_buf;

    assign word_next = word_idx + (ADDR_W+1)'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            len_q          <= '0;
            word_idx       <= '0;
            byte_cnt       <= '0;
            word_buf       <= '0;
            bus.byte_ready <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            core_rst_n     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            bus.mem_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    core_rst_n <= 1'b1;
                    if (start) begin
                        if (len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b0;
                        end else if (len > DEPTH) begin
                            state <= IDLE;
                            done  <= 1'b0;
                            err   <= 1'b1;
                        end else begin
                            len_q          <= len;
                            word_idx       <= '0;
                            byte_cnt       <= '0;
                            err            <= 1'b0;
                            done           <= 1'b0;
                            busy           <= 1'b1;
                            core_rst_n     <= 1'b0;
                            bus.byte_ready <= 1'b1;
                            state          <= RECV;
                        end
                    end
                end
                RECV: begin
                    if (bus.byte_valid && bus.byte_ready) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: word_buf[7:0]   <= bus.byte_data;
                            2'd1: word_buf[15:8]  <= bus.byte_data;
                            2'd2: word_buf[23:16] <= bus.byte_data;
                            default: begin
                                // Fourth byte goes straight into the write data, not the buffer.
                                bus.mem_wdata  <= {bus.byte_data, word_buf};
                                bus.mem_addr   <= {{(30-ADDR_W){1'b0}}, word_idx[ADDR_W-1:0], 2'b00};
                                bus.mem_we     <= 1'b1;
                                bus.byte_ready <= 1'b0;
                                state          <= WRITE;
                            end
                        endcase
                    end
                end
                WRITE: begin
                    word_idx <= word_next;
                    if (word_next == len_q) begin
                        state      <= DONE;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        core_rst_n <= 1'b1;
                    end else begin
                        bus.byte_ready <= 1'b1;
                        state          <= RECV;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed and randomized checks of imem_loader against a word-list model
module tb_imem_loader;
    localparam int ADDR_W = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic [ADDR_W:0] len = '0;
    logic            core_rst_n, busy, done, err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [63:0] wr_q[$];
    logic [7:0]  acc_q[$];
    int          we_bad = 0;
    logic        prev_we = 1'b0;

    imem_loader_if bif();

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .bus        (bif),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bif.byte_valid && bif.byte_ready) acc_q.push_back(bif.byte_data);
    end

    always @(negedge clk) begin
        if (bif.mem_we) begin
            wr_q.push_back({bif.mem_addr, bif.mem_wdata});
            if (prev_we || bif.byte_ready || !busy || core_rst_n) we_bad <= we_bad + 1;
        end
        prev_we <= bif.mem_we;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [ADDR_W:0] l);
        start = 1'b1;
        len   = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offers each byte until taken; optional idle gap between bytes and a stray start at index poke.
    task automatic feed(input logic [7:0] b[$], input int gap, input bit rnd_gap,
                        input int poke, output bit to);
        to = 1'b0;
        foreach (b[i]) begin
            int  n;
            int  g;
            bit  rdy;
            if (i == poke) begin
                start = 1'b1;
                len   = 9'd5;
            end
            bif.byte_valid = 1'b1;
            bif.byte_data  = b[i];
            n = 0;
            forever begin
                rdy = bif.byte_ready;
                @(negedge clk);
                start = 1'b0;
                if (rdy) break;
                n++;
                if (n > 40) begin
                    to = 1'b1;
                    bif.byte_valid = 1'b0;
                    return;
                end
            end
            g = rnd_gap ? int'($urandom_range(0, gap)) : gap;
            if (g > 0 && i < b.size() - 1) begin
                bif.byte_valid = 1'b0;
                repeat (g) @(negedge clk);
            end
        end
        bif.byte_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit to);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        to = !done;
    endtask

    // Model: word w is bytes 4w..4w+3 little-endian, written at byte address 4w.
    task automatic check_writes(input string tag, input logic [7:0] b[$], input int nw,
                                input int wbase, input int abase, input int bad_base);
        int bad;
        logic [31:0] ed;
        bad = 0;
        chk({tag, "_nwr"}, 64'(wr_q.size() - wbase), 64'(nw));
        for (int w = 0; w < nw && wbase + w < wr_q.size(); w++) begin
            ed = 32'(b[4*w]) + 32'(b[4*w+1]) * 256 + 32'(b[4*w+2]) * 65536
               + 32'(b[4*w+3]) * 16777216;
            if (wr_q[wbase + w] !== {32'(4 * w), ed}) bad++;
        end
        chk({tag, "_wdata"}, 64'(bad), 64'd0);
        bad = (acc_q.size() - abase != b.size()) ? 1 : 0;
        for (int k = 0; k < b.size() && abase + k < acc_q.size(); k++)
            if (acc_q[abase + k] !== b[k]) bad++;
        chk({tag, "_bytes"}, 64'(bad), 64'd0);
        chk({tag, "_we_rules"}, 64'(we_bad - bad_base), 64'd0);
    endtask

    initial begin
        logic [7:0] bytes[$];
        bit         to;
        int         wb, ab, bb, c0, n;

        bif.byte_valid = 1'b0;
        bif.byte_data  = 8'h00;

        repeat (2) @(negedge clk);
        chk("rst_flags", 64'({bif.byte_ready, bif.mem_we, core_rst_n, busy, done, err}), 64'd0);
        chk("rst_bus", {bif.mem_addr, bif.mem_wdata}, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rel_flags", 64'({core_rst_n, bif.byte_ready, done, busy}), 64'b1000);

        // Two-word load, continuous stream
        bytes = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
        wb = wr_q.size(); ab = acc_q.size(); bb = we_bad;
        do_start(9'd2);
        c0 = cyc;
        feed(bytes, 0, 1'b0, -1, to);
        chk("two_feed_to", 64'(to), 64'd0);
        wait_done(20, to);
        chk("two_done_to", 64'(to), 64'd0);
        chk("two_cycles", 64'(cyc - c0), 64'd10);
        check_writes("two", bytes, 2, wb, ab, bb);
        chk("two_w0", wr_q[wb], {32'h0, 32'h00500513});
        chk("two_w1", wr_q[wb+1], {32'h4, 32'h00A00593});
        chk("two_end", 64'({done, core_rst_n, busy}), 64'b110);

        // Same load with 3 idle cycles between bytes
        wb = wr_q.size(); ab = acc_q.size(); bb = we_bad;
        do_start(9'd2);
        feed(bytes, 3, 1'b0, -1, to);
        chk("gap_feed_to", 64'(to), 64'd0);
        wait_done(20, to);
        chk("gap_done_to", 64'(to), 64'd0);
        check_writes("gap", bytes, 2, wb, ab, bb);

        // Oversize length
        wb = wr_q.size();
        do_start(9'd257);
        chk("len257_flags", 64'({err, done, busy, core_rst_n, bif.byte_ready}), 64'b10010);
        repeat (3) @(negedge clk);
        chk("len257_nwr", 64'(wr_q.size() - wb), 64'd0);

        // Full-depth load clears err
        bytes.delete();
        for (int i = 0; i < 1024; i++) bytes.push_back(8'($urandom));
        wb = wr_q.size(); ab = acc_q.size(); bb = we_bad;
        do_start(9'd256);
        chk("len256_start", 64'({err, busy, core_rst_n}), 64'b010);
        feed(bytes, 0, 1'b0, -1, to);
        chk("len256_feed_to", 64'(to), 64'd0);
        wait_done(20, to);
        chk("len256_done_to", 64'(to), 64'd0);
        check_writes("len256", bytes, 256, wb, ab, bb);
        chk("len256_last_addr", 64'(wr_q[wr_q.size()-1][63:32]), 64'h3FC);

        // Zero length after an error
        do_start(9'd257);
        wb = wr_q.size();
        do_start(9'd0);
        chk("len0_flags", 64'({done, err, busy, core_rst_n}), 64'b1001);
        repeat (3) @(negedge clk);
        chk("len0_nwr", 64'(wr_q.size() - wb), 64'd0);

        // Start while busy is ignored
        bytes = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'hA0, 8'h00};
        wb = wr_q.size(); ab = acc_q.size(); bb = we_bad;
        do_start(9'd2);
        feed(bytes, 1, 1'b0, 5, to);
        chk("busy_feed_to", 64'(to), 64'd0);
        wait_done(20, to);
        chk("busy_done_to", 64'(to), 64'd0);
        repeat (12) @(negedge clk);
        check_writes("busy", bytes, 2, wb, ab, bb);

        // Randomized loads
        for (int t = 0; t < 4; t++) begin
            n = int'($urandom_range(1, 6));
            bytes.delete();
            for (int i = 0; i < 4 * n; i++) bytes.push_back(8'($urandom));
            wb = wr_q.size(); ab = acc_q.size(); bb = we_bad;
            do_start(9'(n));
            feed(bytes, 2, 1'b1, int'($urandom_range(0, 4 * n)), to);
            chk($sformatf("rnd%0d_feed_to", t), 64'(to), 64'd0);
            wait_done(20, to);
            chk($sformatf("rnd%0d_done_to", t), 64'(to), 64'd0);
            check_writes($sformatf("rnd%0d", t), bytes, n, wb, ab, bb);
        end

        // Reset in the middle of the second word
        bytes.delete();
        for (int i = 0; i < 6; i++) bytes.push_back(8'($urandom));
        wb = wr_q.size();
        do_start(9'd3);
        feed(bytes, 0, 1'b0, -1, to);
        chk("midrst_feed_to", 64'(to), 64'd0);
        rst = 1'b0;
        #1;
        chk("midrst_flags", 64'({bif.byte_ready, bif.mem_we, core_rst_n, busy, done, err}), 64'd0);
        chk("midrst_bus", {bif.mem_addr, bif.mem_wdata}, 64'd0);
        repeat (4) @(negedge clk);
        chk("midrst_nwr", 64'(wr_q.size() - wb), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        bytes.delete();
        for (int i = 0; i < 4; i++) bytes.push_back(8'($urandom));
        wb = wr_q.size(); ab = acc_q.size(); bb = we_bad;
        do_start(9'd1);
        feed(bytes, 0, 1'b0, -1, to);
        chk("fresh_feed_to", 64'(to), 64'd0);
        wait_done(20, to);
        chk("fresh_done_to", 64'(to), 64'd0);
        check_writes("fresh", bytes, 1, wb, ab, bb);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that writes a byte stream into instruction memory through its write port, the writer side of the memory the fetch stage reads. It assembles little-endian bytes into 32-bit instruction words and writes them at consecutive word addresses starting at 0. It holds the core in reset while loading. It sits between a host byte source (UART receiver or bench) and the write port of `inst_mem`, with `core_rst_n` driving the core's `rst`.

## Interface
- `ADDR_W`, 8: word-address width; memory depth is 2**ADDR_W words.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle pulse that begins a load; sampled only in IDLE or DONE.
- `len`  in  ADDR_W+1  number of words to load, sampled with `start`.
- `byte_valid`  in  1  host has a byte on `byte_data`.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  instruction-memory write enable, one-cycle pulse per word.
- `mem_addr`  out  32  byte address of the write, equal to word index × 4.
- `mem_wdata`  out  32  assembled instruction word.
- `core_rst_n`  out  1  active-low reset to the core; low while loading.
- `busy`  out  1  high in RECV or WRITE.
- `done`  out  1  high in DONE.
- `err`  out  1  sticky error flag: set on `len` > 2**ADDR_W; cleared by the next accepted `start`.

## Operation
- States and exits:
  - IDLE: on `start`, go to RECV if 1 ≤ `len` ≤ 2**ADDR_W.
  - RECV: collect four bytes.
  - WRITE: one cycle; issues the memory write.
  - DONE: on `start`, reload (same rules as IDLE).
- All outputs are registered.
- Reset values: state IDLE, `byte_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `core_rst_n`=0, `busy`=0, `done`=0, `err`=0, word counter 0, byte counter 0.
- `start` in IDLE or DONE:
  - `len`=0: go to DONE directly, no writes, `err`=0.
  - `len` > 2**ADDR_W: go to IDLE, `err`=1, no writes.
  - Otherwise: latch `len`, clear the counters, clear `err`, go to RECV.
- `start` in RECV or WRITE is ignored.
- Byte transfer happens on a rising edge where `byte_valid` && `byte_ready`.
  - Byte k of a word (k=0..3) goes into bits [8k+7:8k], little-endian.
  - After the 4th byte, go to WRITE.
- In WRITE:
  - `mem_we`=1, `mem_addr`={word_idx,2'b00} zero-extended to 32 bits, `mem_wdata`=assembled word.
  - Then word_idx increments.
  - If word_idx+1 == `len`, go to DONE; otherwise go to RECV with the byte counter at 0.
- `byte_ready`=1 only in RECV. It is 0 in WRITE, so the host must hold `byte_valid`/`byte_data` until accepted.
- `core_rst_n`=0 in RECV and WRITE, and 1 in IDLE and DONE; it is 0 during reset.
- `busy`=1 in RECV and WRITE only.
- `done`=1 in DONE only.
- Counter widths:
  - Word counter is ADDR_W+1 bits, so `len`=2**ADDR_W is reachable without wrap.
  - Byte counter is 2 bits and wraps 3→0 on entry to WRITE.
- Reset mid-load aborts immediately:
  - All outputs return to their reset values.
  - Partially assembled bytes are discarded.
  - Words already written stay in memory.

## Timing
- Byte acceptance has zero wait states: a byte offered in RECV is taken on the same edge.
- Each word costs 4 accepted-byte cycles plus 1 WRITE cycle; the minimum load time is 5×`len` cycles after `start`.
- `mem_we` is high for exactly 1 cycle per word, and never high outside WRITE.
- DONE is entered on the edge that ends the last WRITE. `core_rst_n` and `done` rise on that edge.
- After reset deasserts, the first rising edge drives `core_rst_n` to 1 (IDLE).

## Test plan
- Reset-release state: hold `rst`=0, then release, with no `start`.
  - While `rst`=0: every output is 0.
  - On the next edge: `core_rst_n`=1, `byte_ready`=0, `done`=0.
- Two-word load: `start` with `len`=2, then bytes 0x13,0x05,0x50,0x00,0x93,0x05,0xA0,0x00 with `byte_valid` held high.
  - Write 1: `mem_we` pulse at `mem_addr`=0, `mem_wdata`=0x00500513.
  - Write 2: pulse at `mem_addr`=4, `mem_wdata`=0x00A00593.
  - Then `done`=1 and `core_rst_n`=1.
  - Exactly 10 cycles from the `start` edge to DONE.
- Gapped stream: same load with `byte_valid` dropped for 3 cycles between every byte.
  - Identical writes and data.
  - No byte is accepted while `byte_valid`=0.
  - `byte_ready`=0 in every WRITE cycle.
- Length boundaries, with ADDR_W=8:
  - `len`=0: DONE next cycle, no `mem_we`.
  - `len`=257: `err`=1, state IDLE, no writes.
  - `len`=256: the last write lands at `mem_addr`=0x3FC, then DONE.
- Start while busy: a second `start` with `len`=5 in the middle of a `len`=2 load is ignored. Exactly 2 writes occur.
- Reset mid-word: assert `rst` after 2 bytes of word 1 of a `len`=3 load.
  - Outputs go to their reset values asynchronously, with no further `mem_we`.
  - A fresh load of `len`=1 then writes its first word to `mem_addr`=0.
